full_bist: RTL and testbench

FULL_BIST -- requirements
Module: full_bist

---
 rtl/full_bist_pkg.sv | 106 ++++++++++
 rtl/full_bist_sram_256x4.sv | 24 ++
 rtl/full_bist.sv | 133 +++++++++++++
 tb/tb_full_bist.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/full_bist_pkg.sv
// rtl/full_bist_pkg.sv - shared encodings, counts and march element table for full_bist
// Ports: none (package).
package full_bist_pkg;

  // Mode select encodings; every other value is treated as normal access.
  localparam logic [2:0] MODE_NORMAL  = 3'd0;
  localparam logic [2:0] MODE_MATS    = 3'd1;
  localparam logic [2:0] MODE_MARCH_C = 3'd2;
  localparam logic [2:0] MODE_CHECKER = 3'd3;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_PASS = 2'd2;
  localparam state_t ST_FAIL = 2'd3;

  localparam logic [11:0] OPS_MATS    = 12'd1280;
  localparam logic [11:0] OPS_MARCH_C = 12'd2560;
  localparam logic [11:0] OPS_CHECKER = 12'd1024;

  localparam logic [3:0] CB_EVEN = 4'b1010;
  localparam logic [3:0] CB_ODD  = 4'b0101;

  typedef enum logic [1:0] {K_ZERO, K_ONE, K_PAT, K_NPAT} data_kind_e;

  // One march element: address direction plus one or two operations per address.
  typedef struct packed {
    logic       down;
    logic       two_ops;
    logic       rd0;
    data_kind_e k0;
    logic       rd1;
    data_kind_e k1;
  } elem_t;

  function automatic logic is_test_mode(input logic [2:0] m);
    return (m == MODE_MATS) || (m == MODE_MARCH_C) || (m == MODE_CHECKER);
  endfunction

  function automatic logic [11:0] op_total(input logic [2:0] m);
    case (m)
      MODE_MATS:    return OPS_MATS;
      MODE_MARCH_C: return OPS_MARCH_C;
      MODE_CHECKER: return OPS_CHECKER;
      default:      return 12'd0;
    endcase
  endfunction

  function automatic logic [3:0] kind_data(input data_kind_e k, input logic [7:0] a);
    case (k)
      K_ZERO:  return 4'b0000;
      K_ONE:   return 4'b1111;
      K_PAT:   return a[0] ? CB_ODD : CB_EVEN;
      default: return a[0] ? ~CB_ODD : ~CB_EVEN;
    endcase
  endfunction

  function automatic elem_t mk_elem(input logic down, input logic two_ops,
                                    input logic rd0, input data_kind_e k0,
                                    input logic rd1, input data_kind_e k1);
    elem_t e;
    e.down    = down;
    e.two_ops = two_ops;
    e.rd0     = rd0;
    e.k0      = k0;
    e.rd1     = rd1;
    e.k1      = k1;
    return e;
  endfunction

  // Element table; "any" order elements run upward.
  function automatic elem_t get_elem(input logic [2:0] m, input logic [2:0] idx);
    elem_t e;
    e = mk_elem(1'b0, 1'b0, 1'b0, K_ZERO, 1'b0, K_ZERO);
    case (m)
      MODE_MATS: begin
        case (idx)
          3'd0:    e = mk_elem(1'b0, 1'b0, 1'b0, K_ZERO, 1'b0, K_ZERO);
          3'd1:    e = mk_elem(1'b0, 1'b1, 1'b1, K_ZERO, 1'b0, K_ONE);
          default: e = mk_elem(1'b1, 1'b1, 1'b1, K_ONE,  1'b0, K_ZERO);
        endcase
      end
      MODE_MARCH_C: begin
        case (idx)
          3'd0:    e = mk_elem(1'b0, 1'b0, 1'b0, K_ZERO, 1'b0, K_ZERO);
          3'd1:    e = mk_elem(1'b0, 1'b1, 1'b1, K_ZERO, 1'b0, K_ONE);
          3'd2:    e = mk_elem(1'b0, 1'b1, 1'b1, K_ONE,  1'b0, K_ZERO);
          3'd3:    e = mk_elem(1'b1, 1'b1, 1'b1, K_ZERO, 1'b0, K_ONE);
          3'd4:    e = mk_elem(1'b1, 1'b1, 1'b1, K_ONE,  1'b0, K_ZERO);
          default: e = mk_elem(1'b0, 1'b0, 1'b1, K_ZERO, 1'b0, K_ZERO);
        endcase
      end
      MODE_CHECKER: begin
        case (idx)
          3'd0:    e = mk_elem(1'b0, 1'b0, 1'b0, K_PAT,  1'b0, K_ZERO);
          3'd1:    e = mk_elem(1'b0, 1'b0, 1'b1, K_PAT,  1'b0, K_ZERO);
          3'd2:    e = mk_elem(1'b0, 1'b0, 1'b0, K_NPAT, 1'b0, K_ZERO);
          default: e = mk_elem(1'b0, 1'b0, 1'b1, K_NPAT, 1'b0, K_ZERO);
        endcase
      end
      default: e = mk_elem(1'b0, 1'b0, 1'b0, K_ZERO, 1'b0, K_ZERO);
    endcase
    return e;
  endfunction

endpackage

// File: rtl/full_bist_sram_256x4.sv
// rtl/full_bist_sram_256x4.sv - 256x4 storage array, synchronous write, combinational read
// Ports: clk (write clock), we (write enable), addr[7:0], din[3:0] (write data),
//        dout[3:0] (combinational read of addr). Contents are never reset.
module sram_256x4 (
  input  logic       clk,
  input  logic       we,
  input  logic [7:0] addr,
  input  logic [3:0] din,
  output logic [3:0] dout
);

  logic [3:0] mem_q [256];
  logic [3:0] rd_word;

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= din;
    end
  end

  assign rd_word = mem_q[addr];
  assign dout    = rd_word;

endmodule

// File: rtl/full_bist.sv
// rtl/full_bist.sv - SRAM wrapper with MATS+, March C- and checkerboard BIST engine
// Ports: clk, rst_n (async active-low), What_Do_You_Want_To_Check[2:0] (mode select),
//        WE/Address[7:0]/Data_Input[3:0] (user access, normal mode only),
//        Data_output[3:0] (word at the active address), GoNoGo (1 only after a passing test).
module full_bist
  import full_bist_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] What_Do_You_Want_To_Check,
  input  logic       WE,
  input  logic [7:0] Address,
  input  logic [3:0] Data_Input,
  output logic [3:0] Data_output,
  output logic       GoNoGo
);

  logic [2:0]  mode_q, mode_d;
  state_t      state_q, state_d;
  logic [2:0]  elem_q, elem_d;
  logic [7:0]  addr_q, addr_d;
  logic        op_q, op_d;
  logic        err_q, err_d;
  logic [11:0] cnt_q, cnt_d;

  logic        start;
  logic        run_op;
  elem_t       elem;
  elem_t       nxt_elem;
  elem_t       first_elem;
  logic        cur_rd;
  data_kind_e  cur_kind;
  logic [3:0]  exp_data;
  logic        mismatch;
  logic        at_end;
  logic        last_op;
  logic        user_owns;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [3:0]  mem_din;
  logic [3:0]  mem_dout;

  assign start      = (What_Do_You_Want_To_Check != mode_q);
  // A pending restart suppresses the operation of the test being aborted.
  assign run_op     = (state_q == ST_RUN) && !start;
  assign elem       = get_elem(mode_q, elem_q);
  assign nxt_elem   = get_elem(mode_q, elem_q + 3'd1);
  assign first_elem = get_elem(What_Do_You_Want_To_Check, 3'd0);
  assign cur_rd     = op_q ? elem.rd1 : elem.rd0;
  assign cur_kind   = op_q ? elem.k1 : elem.k0;
  assign exp_data   = kind_data(cur_kind, addr_q);
  assign mismatch   = run_op && cur_rd && (mem_dout != exp_data);
  assign at_end     = elem.down ? (addr_q == 8'h00) : (addr_q == 8'hFF);
  assign last_op    = (cnt_q == (op_total(mode_q) - 12'd1));

  // The user owns the array only while idle, and loses it as soon as a test is selected.
  assign user_owns  = (state_q == ST_IDLE);
  assign mem_addr   = user_owns ? Address : addr_q;
  assign mem_din    = user_owns ? Data_Input : exp_data;
  assign mem_we     = user_owns ? (WE && !is_test_mode(What_Do_You_Want_To_Check))
                                : (run_op && !cur_rd);

  sram_256x4 u_sram (
    .clk  (clk),
    .we   (mem_we),
    .addr (mem_addr),
    .din  (mem_din),
    .dout (mem_dout)
  );

  assign Data_output = mem_dout;
  assign GoNoGo      = (state_q == ST_PASS);

  always_comb begin
    mode_d  = What_Do_You_Want_To_Check;
    state_d = state_q;
    elem_d  = elem_q;
    addr_d  = addr_q;
    op_d    = op_q;
    err_d   = err_q | mismatch;
    cnt_d   = cnt_q;
    if (start) begin
      err_d  = 1'b0;
      op_d   = 1'b0;
      elem_d = 3'd0;
      cnt_d  = 12'd0;
      if (is_test_mode(What_Do_You_Want_To_Check)) begin
        state_d = ST_RUN;
        addr_d  = first_elem.down ? 8'hFF : 8'h00;
      end else begin
        state_d = ST_IDLE;
        addr_d  = 8'h00;
      end
    end else if (run_op) begin
      cnt_d = cnt_q + 12'd1;
      if (elem.two_ops && !op_q) begin
        op_d = 1'b1;
      end else begin
        op_d = 1'b0;
        if (!at_end) begin
          addr_d = elem.down ? (addr_q - 8'd1) : (addr_q + 8'd1);
        end else begin
          elem_d = elem_q + 3'd1;
          addr_d = nxt_elem.down ? 8'hFF : 8'h00;
        end
      end
      if (last_op) begin
        state_d = (err_q || mismatch) ? ST_FAIL : ST_PASS;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q  <= MODE_NORMAL;
      state_q <= ST_IDLE;
      elem_q  <= 3'd0;
      addr_q  <= 8'h00;
      op_q    <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= 12'd0;
    end else begin
      mode_q  <= mode_d;
      state_q <= state_d;
      elem_q  <= elem_d;
      addr_q  <= addr_d;
      op_q    <= op_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_full_bist.sv
// tb/tb_full_bist.sv - self-checking bench for full_bist against a march-algorithm model
module tb_full_bist;

  logic       clk;
  logic       rst_n;
  logic [2:0] mode;
  logic       we;
  logic [7:0] addr;
  logic [3:0] din;
  logic [3:0] dout;
  logic       go;

  int checks = 0;
  int errors = 0;

  logic [3:0] ref_mem [256];
  bit         ref_fail;
  int         ref_ops;
  bit         fault_on = 0;

  full_bist dut (
    .clk                       (clk),
    .rst_n                     (rst_n),
    .What_Do_You_Want_To_Check (mode),
    .WE                        (we),
    .Address                   (addr),
    .Data_Input                (din),
    .Data_output               (dout),
    .GoNoGo                    (go)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference memory model: writes honour the planted stuck-at bit, reads compare.
  task automatic m_w(input int a, input logic [3:0] d);
    logic [3:0] v;
    v = d;
    if (fault_on && a == 16) v[2] = 1'b0;
    ref_mem[a] = v;
    ref_ops++;
  endtask

  task automatic m_r(input int a, input logic [3:0] e);
    if (ref_mem[a] !== e) ref_fail = 1;
    ref_ops++;
  endtask

  function automatic logic [3:0] pat(input int a);
    return (a % 2 == 1) ? 4'h5 : 4'hA;
  endfunction

  task automatic model_run(input int m);
    ref_ops  = 0;
    ref_fail = 0;
    if (m == 1) begin
      for (int a = 0; a < 256; a++) m_w(a, 4'h0);
      for (int a = 0; a < 256; a++) begin m_r(a, 4'h0); m_w(a, 4'hF); end
      for (int a = 255; a >= 0; a--) begin m_r(a, 4'hF); m_w(a, 4'h0); end
    end else if (m == 2) begin
      for (int a = 0; a < 256; a++) m_w(a, 4'h0);
      for (int a = 0; a < 256; a++) begin m_r(a, 4'h0); m_w(a, 4'hF); end
      for (int a = 0; a < 256; a++) begin m_r(a, 4'hF); m_w(a, 4'h0); end
      for (int a = 255; a >= 0; a--) begin m_r(a, 4'h0); m_w(a, 4'hF); end
      for (int a = 255; a >= 0; a--) begin m_r(a, 4'hF); m_w(a, 4'h0); end
      for (int a = 0; a < 256; a++) m_r(a, 4'h0);
    end else begin
      for (int a = 0; a < 256; a++) m_w(a, pat(a));
      for (int a = 0; a < 256; a++) m_r(a, pat(a));
      for (int a = 0; a < 256; a++) m_w(a, ~pat(a));
      for (int a = 0; a < 256; a++) m_r(a, ~pat(a));
    end
  endtask

  function automatic int mem_bad();
    int bad;
    bad = 0;
    for (int a = 0; a < 256; a++) begin
      if (dut.u_sram.mem_q[a] !== ref_mem[a]) bad++;
    end
    return bad;
  endfunction

  initial begin
    int          highs;
    logic [7:0]  a;
    logic [3:0]  d;
    logic [7:0]  wq[$];

    rst_n = 1'b0;
    mode  = 3'd0;
    we    = 1'b0;
    addr  = 8'h00;
    din   = 4'h0;
    tick(2);
    chk("reset_gonogo", {15'd0, go}, 16'd0);
    chk("reset_mode_q", {13'd0, dut.mode_q}, 16'd0);
    chk("reset_addr_q", {8'd0, dut.addr_q}, 16'd0);
    rst_n = 1'b1;
    tick(1);

    // Normal mode write/read of 0x3C.
    addr = 8'h3C; din = 4'hA; we = 1'b1;
    tick(1);
    we = 1'b0;
    ref_mem[8'h3C] = 4'hA;
    chk("normal_read_3c", {12'd0, dout}, 16'h000A);
    chk("normal_gonogo", {15'd0, go}, 16'd0);

    // Random user traffic, read back after all writes.
    for (int i = 0; i < 16; i++) begin
      a = 8'($urandom_range(0, 255));
      d = 4'($urandom);
      addr = a; din = d; we = 1'b1;
      tick(1);
      ref_mem[a] = d;
      wq.push_back(a);
    end
    we = 1'b0;
    foreach (wq[i]) begin
      addr = wq[i];
      #1;
      chk("normal_rand_read", {12'd0, dout}, {12'd0, ref_mem[wq[i]]});
    end

    // Reset, then MATS+; user WE held high throughout and must be ignored.
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    tick(1);
    we = 1'b1; addr = 8'h3C; din = 4'hF;
    mode = 3'd1;
    model_run(1);
    chk("mats_op_count", 16'(ref_ops), 16'd1280);
    tick(ref_ops - 1);
    chk("mats_running", {15'd0, go}, 16'd0);
    tick(4);
    chk("mats_gonogo", {15'd0, go}, {15'd0, !ref_fail});
    chk("mats_mem", 16'(mem_bad()), 16'd0);

    // March C-.
    mode = 3'd2;
    model_run(2);
    tick(ref_ops - 1);
    chk("march_running", {15'd0, go}, 16'd0);
    tick(4);
    chk("march_gonogo", {15'd0, go}, {15'd0, !ref_fail});
    chk("march_mem", 16'(mem_bad()), 16'd0);

    // Checkerboard.
    mode = 3'd3;
    model_run(3);
    tick(ref_ops - 1);
    chk("cb_running", {15'd0, go}, 16'd0);
    tick(4);
    chk("cb_gonogo", {15'd0, go}, {15'd0, !ref_fail});
    chk("cb_word00", {12'd0, dut.u_sram.mem_q[0]}, 16'h0005);
    chk("cb_word01", {12'd0, dut.u_sram.mem_q[1]}, 16'h000A);
    chk("cb_mem", 16'(mem_bad()), 16'd0);

    // Stuck-at-0 on bit 2 of word 0x10 during March C-.
    force dut.u_sram.rd_word = dut.u_sram.mem_q[dut.u_sram.addr] &
                               ((dut.u_sram.addr == 8'h10) ? 4'b1011 : 4'b1111);
    fault_on = 1;
    mode = 3'd2;
    model_run(2);
    highs = 0;
    for (int i = 0; i < 3010; i++) begin
      tick(1);
      if (go) highs++;
    end
    chk("fault_pass_cycles", 16'(highs), 16'd0);
    chk("fault_gonogo", {15'd0, go}, {15'd0, !ref_fail});
    release dut.u_sram.rd_word;
    fault_on = 0;

    // MATS+ aborted at cycle 500 by a switch to checkerboard.
    mode = 3'd1;
    tick(500);
    mode = 3'd3;
    model_run(3);
    tick(1022);
    chk("abort_cb_running", {15'd0, go}, 16'd0);
    tick(5);
    chk("abort_cb_gonogo", {15'd0, go}, {15'd0, !ref_fail});
    chk("abort_cb_mem", 16'(mem_bad()), 16'd0);

    // Asynchronous reset mid-cycle drops GoNoGo at once; memory survives.
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_gonogo", {15'd0, go}, 16'd0);
    chk("reset_keeps_mem", 16'(mem_bad()), 16'd0);
    tick(2);
    rst_n = 1'b1;
    model_run(3);
    tick(1022);
    chk("post_reset_running", {15'd0, go}, 16'd0);
    tick(5);
    chk("post_reset_gonogo", {15'd0, go}, {15'd0, !ref_fail});

    // Mode 5 is normal access: random write and immediate read-back.
    we = 1'b0;
    mode = 3'd5;
    tick(2);
    chk("mode5_gonogo", {15'd0, go}, 16'd0);
    for (int i = 0; i < 8; i++) begin
      a = 8'($urandom_range(0, 255));
      d = 4'($urandom);
      addr = a; din = d; we = 1'b1;
      tick(1);
      we = 1'b0;
      ref_mem[a] = d;
      chk("mode5_write_read", {12'd0, dout}, {12'd0, d});
    end
    for (int i = 0; i < 8; i++) begin
      addr = 8'($urandom_range(0, 255));
      #1;
      chk("mode5_rand_read", {12'd0, dout}, {12'd0, ref_mem[addr]});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
